// File: rtl/rhd_seq_pkg.sv
// Shared types and constants for the RHD acquisition sequencer.
package rhd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_WAIT_RDY
    } seq_state_t;

    localparam logic [1:0]  CMD_CONVERT_HI = 2'b00;
    localparam logic [15:0] CMD_FLUSH      = 16'hFF00;
    localparam int unsigned PIPE_LAT       = 2;

    function automatic logic [15:0] convert_cmd(input logic [5:0] ch);
        return {CMD_CONVERT_HI, ch, 8'h00};
    endfunction

endpackage

// File: rtl/rhd_seq_out_reg.sv
// One-deep valid/ready holding register for tagged A/B result pairs.
// A capture arriving while the held word is still unaccepted is dropped.
module rhd_seq_out_reg #(
    parameter int unsigned CH_W = 6
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [15:0]     in_a,
    input  logic [15:0]     in_b,
    input  logic [CH_W-1:0] in_chan,
    input  logic            in_first,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [15:0]     out_a,
    output logic [15:0]     out_b,
    output logic [CH_W-1:0] out_chan,
    output logic            out_first,
    output logic            drop
);

    logic load;

    assign load = in_valid && (!out_valid || out_ready);
    assign drop = in_valid && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_chan  <= '0;
            out_first <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_a     <= in_a;
            out_b     <= in_b;
            out_chan  <= in_chan;
            out_first <= in_first;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rhd_acq_sequencer.sv
// Frame scheduler for rhd_spi_master: CONVERT per channel, optional aux, two flushes.
// Define RHD_SEQ_AUX_EN to insert the auxiliary command slot after the channels.
module rhd_acq_sequencer
    import rhd_seq_pkg::*;
#(
    parameter int unsigned NUM_CH = 32,
    parameter int unsigned CH_W   = 6
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enable,
    input  logic            frame_tick,
    input  logic            clear,
    input  logic [15:0]     aux_cmd,
    output logic            spi_start,
    output logic [15:0]     spi_cmd,
    input  logic            spi_done,
    input  logic [15:0]     spi_a_data,
    input  logic [15:0]     spi_b_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_a,
    output logic [15:0]     out_b,
    output logic [CH_W-1:0] out_chan,
    output logic            out_first,
    output logic            busy,
    output logic            overrun,
    output logic            frame_miss
);

`ifdef RHD_SEQ_AUX_EN
    localparam int unsigned AUX_SLOTS = 1;
`else
    localparam int unsigned AUX_SLOTS = 0;
`endif
    localparam int unsigned T  = NUM_CH + AUX_SLOTS + PIPE_LAT;
    localparam int unsigned XW = 7;

    seq_state_t      state;
    logic [XW-1:0]   xfer;
    logic [XW-1:0]   next_xfer;
    logic [15:0]     next_cmd;
    logic            done_q;
    logic            done_rise;
    logic            last_xfer;
    logic            cap_valid;
    logic [CH_W-1:0] cap_chan;
    logic            cap_first;
    logic            drop;

    assign next_xfer = (state == ST_IDLE) ? '0 : xfer + XW'(1);
    assign done_rise = spi_done && !done_q;
    assign last_xfer = (xfer == XW'(T - 1));
    assign busy      = (state != ST_IDLE);

    // Transfer s returns the result of slot s-PIPE_LAT; the first two carry nothing.
    assign cap_valid = (state == ST_WAIT_DONE) && done_rise && (xfer >= XW'(PIPE_LAT));
    assign cap_chan  = CH_W'(xfer - XW'(PIPE_LAT));
    assign cap_first = (xfer == XW'(PIPE_LAT));

    always_comb begin
        next_cmd = CMD_FLUSH;
        if (next_xfer < XW'(NUM_CH)) begin
            next_cmd = convert_cmd(next_xfer[5:0]);
        end
`ifdef RHD_SEQ_AUX_EN
        else if (next_xfer == XW'(NUM_CH)) begin
            next_cmd = aux_cmd;
        end
`endif
    end

`ifndef RHD_SEQ_AUX_EN
    logic unused_aux;
    assign unused_aux = ^aux_cmd;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            xfer      <= '0;
            spi_start <= 1'b0;
            spi_cmd   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= spi_done;
            spi_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_tick && enable) begin
                        state     <= ST_ISSUE;
                        xfer      <= next_xfer;
                        spi_cmd   <= next_cmd;
                        spi_start <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (done_rise) begin
                        state <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (!spi_done) begin
                        if (last_xfer || !enable) begin
                            state <= ST_IDLE;
                        end else begin
                            state     <= ST_ISSUE;
                            xfer      <= next_xfer;
                            spi_cmd   <= next_cmd;
                            spi_start <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Set events take priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun    <= 1'b0;
            frame_miss <= 1'b0;
        end else begin
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear) begin
                overrun <= 1'b0;
            end
            if (frame_tick && (state != ST_IDLE)) begin
                frame_miss <= 1'b1;
            end else if (clear) begin
                frame_miss <= 1'b0;
            end
        end
    end

    rhd_seq_out_reg #(
        .CH_W(CH_W)
    ) u_out_reg (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (cap_valid),
        .in_a      (spi_a_data),
        .in_b      (spi_b_data),
        .in_chan   (cap_chan),
        .in_first  (cap_first),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_chan  (out_chan),
        .out_first (out_first),
        .drop      (drop)
    );

endmodule

// File: tb/tb_rhd_acq_sequencer.sv
// Self-checking bench for rhd_acq_sequencer with a behavioural SPI master and frame model.
module tb_rhd_acq_sequencer;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 6;
`ifdef RHD_SEQ_AUX_EN
    localparam int unsigned AUXN = 1;
`else
    localparam int unsigned AUXN = 0;
`endif
    localparam int unsigned T = NUM_CH + AUXN + 2;

    logic            clk;
    logic            rstn;
    logic            enable;
    logic            frame_tick;
    logic            clear;
    logic [15:0]     aux_cmd;
    logic            spi_start;
    logic [15:0]     spi_cmd;
    logic            spi_done;
    logic [15:0]     spi_a_data;
    logic [15:0]     spi_b_data;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_a;
    logic [15:0]     out_b;
    logic [CH_W-1:0] out_chan;
    logic            out_first;
    logic            busy;
    logic            overrun;
    logic            frame_miss;

    typedef struct packed {
        logic [CH_W-1:0] chan;
        logic [15:0]     a;
        logic [15:0]     b;
        logic            first;
    } res_t;

    res_t        out_q[$];
    logic [15:0] cmd_q[$];
    logic [15:0] b_hist[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          rdy_mode = 0;
    logic [15:0] aux_val = '0;

    rhd_acq_sequencer #(
        .NUM_CH(NUM_CH),
        .CH_W  (CH_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .frame_tick (frame_tick),
        .clear      (clear),
        .aux_cmd    (aux_cmd),
        .spi_start  (spi_start),
        .spi_cmd    (spi_cmd),
        .spi_done   (spi_done),
        .spi_a_data (spi_a_data),
        .spi_b_data (spi_b_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_chan   (out_chan),
        .out_first  (out_first),
        .busy       (busy),
        .overrun    (overrun),
        .frame_miss (frame_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPI master model: done rises a few cycles after start, a = A000 + transfer number.
    initial begin
        int dly;
        int hold;
        int ph;
        ph = 0; dly = 0; hold = 0;
        spi_done = 1'b0; spi_a_data = '0; spi_b_data = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                ph = 0;
                spi_done = 1'b0;
            end else begin
                case (ph)
                    0: if (spi_start) begin
                        cmd_q.push_back(spi_cmd);
                        dly = $urandom_range(2, 6);
                        ph = 1;
                    end
                    1: if (dly == 0) begin
                        spi_a_data = 16'hA000 + 16'(cmd_q.size() - 1);
                        spi_b_data = 16'($urandom);
                        b_hist.push_back(spi_b_data);
                        spi_done = 1'b1;
                        hold = $urandom_range(1, 3);
                        ph = 2;
                    end else begin
                        dly--;
                    end
                    2: if (hold == 0) begin
                        spi_done = 1'b0;
                        ph = 0;
                    end else begin
                        hold--;
                    end
                    default: ph = 0;
                endcase
            end
        end
    end

    // Downstream ready: mode 0 always, 1 random (never low more than two cycles), 2 never.
    initial begin
        int low_run;
        low_run = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                out_ready = 1'b1;
            end else if (rdy_mode == 2) begin
                out_ready = 1'b0;
            end else begin
                out_ready = (low_run >= 2) ? 1'b1 : ($urandom_range(0, 1) == 1);
                low_run = out_ready ? 0 : low_run + 1;
            end
        end
    end

    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rstn && out_valid && out_ready) begin
                r.chan  = out_chan;
                r.a     = out_a;
                r.b     = out_b;
                r.first = out_first;
                out_q.push_back(r);
            end
        end
    end

    function automatic logic [15:0] exp_cmd(input int i);
        if (i < int'(NUM_CH)) return 16'(i * 256);
        if (AUXN == 1 && i == int'(NUM_CH)) return aux_val;
        return 16'hFF00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic start_frame(input string tag);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk({tag, "_start"}, spi_start, 1);
        chk({tag, "_cmd0"}, spi_cmd, 16'h0000);
        chk({tag, "_busy"}, busy, 1);
    endtask

    task automatic wait_idle(input string tag, input bit drain);
        int cyc;
        cyc = 0;
        while ((busy || (drain && out_valid)) && cyc < 3000) begin
            step();
            cyc++;
        end
        chk({tag, "_idle"}, busy, 0);
        step();
    endtask

    task automatic wait_cmds(input string tag, input int n);
        int cyc;
        cyc = 0;
        while (cmd_q.size() < n && cyc < 3000) begin
            step();
            cyc++;
        end
        chk({tag, "_ncmd_reached"}, 32'(cmd_q.size() >= n), 1);
    endtask

    task automatic verify_frame(input string tag, input int nx, input int no);
        chk({tag, "_ncmd"}, cmd_q.size(), nx);
        for (int i = 0; i < cmd_q.size() && i < nx; i++)
            chk($sformatf("%s_cmd%0d", tag, i), cmd_q[i], exp_cmd(i));
        chk({tag, "_nout"}, out_q.size(), no);
        for (int k = 0; k < out_q.size() && k < no; k++) begin
            chk($sformatf("%s_chan%0d", tag, k), out_q[k].chan, k);
            chk($sformatf("%s_a%0d", tag, k), out_q[k].a, 16'hA000 + 16'(k + 2));
            if (k + 2 < b_hist.size())
                chk($sformatf("%s_b%0d", tag, k), out_q[k].b, b_hist[k + 2]);
            chk($sformatf("%s_first%0d", tag, k), out_q[k].first, (k == 0));
        end
        cmd_q.delete();
        out_q.delete();
        b_hist.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_spi_start"}, spi_start, 0);
        chk({tag, "_spi_cmd"}, spi_cmd, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_frame_miss"}, frame_miss, 0);
        chk({tag, "_out_first"}, out_first, 0);
        chk({tag, "_out_a"}, out_a, 0);
        chk({tag, "_out_b"}, out_b, 0);
        chk({tag, "_out_chan"}, out_chan, 0);
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; frame_tick = 1'b0; clear = 1'b0; aux_cmd = '0;
        step(3);
        check_reset_vals("rst");
        rstn = 1'b1;
        enable = 1'b1;
        step(2);

        // Directed frame, ready held high
        aux_val = 16'hE800;
        aux_cmd = aux_val;
        start_frame("f0");
        wait_idle("f0", 1);
        verify_frame("f0", T, T - 2);

        // Randomized frames with random downstream back-pressure
        rdy_mode = 1;
        for (int f = 0; f < 4; f++) begin
            aux_val = 16'($urandom);
            aux_cmd = aux_val;
            step($urandom_range(0, 5));
            start_frame($sformatf("rf%0d", f));
            wait_idle($sformatf("rf%0d", f), 1);
            verify_frame($sformatf("rf%0d", f), T, T - 2);
        end
        chk("rf_overrun", overrun, 0);
        chk("rf_frame_miss", frame_miss, 0);

        // Downstream stalled for a whole frame
        rdy_mode = 2;
        step(2);
        start_frame("stall");
        wait_idle("stall", 0);
        chk("stall_valid", out_valid, 1);
        chk("stall_chan", out_chan, 0);
        chk("stall_a", out_a, 16'hA002);
        chk("stall_first", out_first, 1);
        chk("stall_overrun", overrun, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("stall_overrun_clr", overrun, 0);
        chk("stall_still_valid", out_valid, 1);
        rdy_mode = 0;
        step(3);
        chk("stall_drain_n", out_q.size(), 1);
        if (out_q.size() > 0) chk("stall_drain_a", out_q[0].a, 16'hA002);
        cmd_q.delete(); out_q.delete(); b_hist.delete();

        // Tick while busy
        rdy_mode = 1;
        start_frame("miss");
        wait_cmds("miss", 3);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("miss_set", frame_miss, 1);
        frame_tick = 1'b1;
        clear = 1'b1;
        step();
        frame_tick = 1'b0;
        clear = 1'b0;
        chk("miss_set_beats_clear", frame_miss, 1);
        wait_idle("miss", 1);
        verify_frame("miss", T, T - 2);
        chk("miss_sticky", frame_miss, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("miss_clr", frame_miss, 0);

        // Enable dropped during transfer 1
        start_frame("en");
        wait_cmds("en", 2);
        enable = 1'b0;
        wait_idle("en", 1);
        verify_frame("en", 2, 0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("en_off_no_start", busy, 0);
        chk("en_off_no_miss", frame_miss, 0);
        enable = 1'b1;
        step(2);
        start_frame("en2");
        wait_idle("en2", 1);
        verify_frame("en2", T, T - 2);

        // Asynchronous reset while waiting for done
        start_frame("ar");
        wait_cmds("ar", 3);
        #1;
        rstn = 1'b0;
        #1;
        check_reset_vals("ar");
        step(2);
        cmd_q.delete(); out_q.delete(); b_hist.delete();
        rstn = 1'b1;
        step(2);
        start_frame("ar2");
        wait_idle("ar2", 1);
        verify_frame("ar2", T, T - 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
